// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
//   Shared constants and helpers for the stream demultiplexer.
//   - Default widths/channel count used by stream_demux.
//   - Saturation value of the default drop counter.
//   - Slice helper locating channel i inside the flattened out_data bus.
// ---------------------------------------------------------------------------
package demux_pkg;

    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_NUM_OUT = 3;
    localparam int unsigned DEF_SEL_W   = 2;
    localparam int unsigned DEF_CNT_W   = 8;

    // Largest value the default-width drop counter may hold before it sticks.
    localparam int unsigned DEF_DROP_SAT = (2 ** DEF_CNT_W) - 1;

    // Lowest bit of channel `ch` inside a bus of `w`-bit channel slices.
    function automatic int unsigned slice_lo(input int unsigned ch, input int unsigned w);
        return ch * w;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// ---------------------------------------------------------------------------
// demux_slot
//   One-entry holding register for a single demux output channel.
//   The slot is either EMPTY or FULL. A load always wins over a drain, which
//   gives the reload-while-draining behaviour needed for 1 beat/cycle.
//   The caller only asserts i_load when the slot is empty or draining, so a
//   full, stalled slot is never overwritten.
//
//   Ports
//     clk      in   clock, rising edge
//     reset    in   asynchronous active-high reset
//     i_load   in   capture i_data this cycle
//     i_data   in   beat payload
//     i_ready  in   downstream consumer accepts this cycle
//     o_valid  out  slot holds a beat (registered)
//     o_data   out  held beat (registered, stable while stalled)
// ---------------------------------------------------------------------------
module demux_slot #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              w_drain;

    assign w_drain = r_valid & i_ready;

    // Slot occupancy: EMPTY->FULL on load, FULL->EMPTY on drain without load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end else if (w_drain) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Payload register: only written on load, so data stays frozen while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= {DATA_W{1'b0}};
        end else if (i_load) begin
            r_data <= i_data;
        end else begin
            r_data <= r_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/stream_demux.sv
// ---------------------------------------------------------------------------
// stream_demux
//   1-to-NUM_OUT registered stream demultiplexer with valid/ready handshake.
//   Each input beat is routed to the channel named by in_select and captured
//   in that channel's one-entry slot (1 cycle latency). Beats whose select is
//   out of range are always accepted, discarded, and counted in a saturating
//   drop counter with a one-cycle drop_pulse the cycle after.
//
//   Ports
//     clk         in   clock, rising edge
//     reset       in   asynchronous active-high reset
//     in_valid    in   input beat present
//     in_ready    out  beat can be accepted this cycle (combinational)
//     in_data     in   input payload
//     in_select   in   destination channel
//     out_valid   out  per-channel slot full
//     out_ready   in   per-channel consumer accepts
//     out_data    out  channel i at [i*DATA_W +: DATA_W]
//     drop_count  out  saturating count of dropped beats
//     drop_pulse  out  high for the cycle after a drop
// ---------------------------------------------------------------------------
module stream_demux
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned NUM_OUT = DEF_NUM_OUT,
    parameter int unsigned SEL_W   = DEF_SEL_W,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [SEL_W-1:0]          in_select,
    output logic [NUM_OUT-1:0]        out_valid,
    input  logic [NUM_OUT-1:0]        out_ready,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]          drop_count,
    output logic                      drop_pulse
);

    localparam int unsigned SEL_SPAN = 2 ** SEL_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Per-select readiness over the full select space. Codes with no channel
    // behind them read as ready because those beats are dropped, never held.
    logic [SEL_SPAN-1:0] w_sel_ready;
    logic [NUM_OUT-1:0]  w_load;
    logic [NUM_OUT-1:0]  w_slot_valid;
    logic                w_accept;
    logic                w_in_range;
    logic                w_drop;
    logic [CNT_W-1:0]    r_drop_count;
    logic                r_drop_pulse;

    assign w_in_range = ({1'b0, in_select} < (SEL_W + 1)'(NUM_OUT));
    assign in_ready   = w_sel_ready[in_select];
    assign w_accept   = in_valid & in_ready;
    assign w_drop     = w_accept & ~w_in_range;

    genvar g;
    generate
        for (g = 0; g < SEL_SPAN; g = g + 1) begin : g_sel_ready
            if (g < NUM_OUT) begin : g_chan
                // Slot can take a beat if empty or emptying this very cycle.
                assign w_sel_ready[g] = ~w_slot_valid[g] | out_ready[g];
            end else begin : g_none
                assign w_sel_ready[g] = 1'b1;
            end
        end

        for (g = 0; g < NUM_OUT; g = g + 1) begin : g_slot
            assign w_load[g] = w_accept & (in_select == SEL_W'(g));

            demux_slot #(
                .DATA_W (DATA_W)
            ) u_slot (
                .clk     (clk),
                .reset   (reset),
                .i_load  (w_load[g]),
                .i_data  (in_data),
                .i_ready (out_ready[g]),
                .o_valid (w_slot_valid[g]),
                .o_data  (out_data[slice_lo(g, DATA_W) +: DATA_W])
            );
        end
    endgenerate

    assign out_valid = w_slot_valid;

    // Drop counter: counts discarded beats and sticks at its maximum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_count <= {CNT_W{1'b0}};
        end else if (w_drop && (r_drop_count != CNT_MAX)) begin
            r_drop_count <= r_drop_count + CNT_W'(1);
        end else begin
            r_drop_count <= r_drop_count;
        end
    end

    // Drop pulse: registered so it appears exactly one cycle after the drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_pulse <= 1'b0;
        end else begin
            r_drop_pulse <= w_drop;
        end
    end

    assign drop_count = r_drop_count;
    assign drop_pulse = r_drop_pulse;

endmodule

// File: tb/tb_stream_demux.sv
// ---------------------------------------------------------------------------
// tb_stream_demux
//   Self-checking bench for stream_demux (3 channels, 2-bit select, 2-bit
//   drop counter so saturation is reachable). Expected behaviour comes from a
//   model holding one queue of outstanding beats per channel plus a count of
//   dropped beats.
// ---------------------------------------------------------------------------
module tb_stream_demux;

    localparam int DW = 8;
    localparam int NO = 3;
    localparam int SW = 2;
    localparam int CW = 2;
    localparam int CNT_SAT = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic [SW-1:0]     in_select;
    logic [NO-1:0]     out_valid;
    logic [NO-1:0]     out_ready;
    logic [NO*DW-1:0]  out_data;
    logic [CW-1:0]     drop_count;
    logic              drop_pulse;

    logic [DW-1:0] m_q [NO][$];
    int            m_drops;
    bit            m_pulse;
    int            n_checks = 0;
    int            n_errors = 0;

    always #5 clk = ~clk;

    stream_demux #(
        .DATA_W  (DW),
        .NUM_OUT (NO),
        .SEL_W   (SW),
        .CNT_W   (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_select  (in_select),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .drop_count (drop_count),
        .drop_pulse (drop_pulse)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < NO; i++) begin
            check_eq($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(m_q[i].size() != 0));
            if (m_q[i].size() != 0)
                check_eq($sformatf("out_data[%0d]", i), 32'(out_data[i*DW +: DW]), 32'(m_q[i][0]));
        end
        check_eq("drop_count", 32'(drop_count), 32'((m_drops > CNT_SAT) ? CNT_SAT : m_drops));
        check_eq("drop_pulse", 32'(drop_pulse), 32'(m_pulse));
    endtask

    // One clock cycle: drive at negedge, check in_ready, model the edge, check outputs.
    task automatic step(input bit v, input logic [SW-1:0] s, input logic [DW-1:0] d,
                        input logic [NO-1:0] ordy, output bit acc);
        bit exp_rdy;
        in_valid  = v;
        in_select = s;
        in_data   = d;
        out_ready = ordy;
        #1;
        exp_rdy = (int'(s) >= NO) ? 1'b1 : ((m_q[s].size() == 0) || ordy[s]);
        check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        for (int i = 0; i < NO; i++)
            if (m_q[i].size() != 0 && ordy[i]) void'(m_q[i].pop_front());
        m_pulse = 1'b0;
        acc = v && exp_rdy;
        if (acc) begin
            if (int'(s) < NO) m_q[s].push_back(d);
            else begin
                m_drops++;
                m_pulse = 1'b1;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic model_clear();
        for (int i = 0; i < NO; i++) m_q[i].delete();
        m_drops = 0;
        m_pulse = 1'b0;
    endtask

    bit            acc;
    bit            pend;
    logic [SW-1:0] p_sel;
    logic [DW-1:0] p_dat;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_select = '0;
        out_ready = '0;
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_outputs();

        // Basic routing
        step(1'b1, 2'd1, 8'hA5, 3'b111, acc);
        step(1'b0, 2'd0, 8'h00, 3'b111, acc);

        // Backpressure on channel 0
        step(1'b1, 2'd0, 8'h10, 3'b110, acc);
        step(1'b1, 2'd0, 8'h20, 3'b110, acc);
        step(1'b1, 2'd0, 8'h20, 3'b110, acc);
        step(1'b1, 2'd0, 8'h20, 3'b111, acc);
        check_eq("bp_accept", 32'(acc), 32'd1);
        step(1'b0, 2'd0, 8'h00, 3'b110, acc);

        // Independence: channel 0 stalled, beat to channel 2
        step(1'b1, 2'd2, 8'h55, 3'b110, acc);
        check_eq("indep_accept", 32'(acc), 32'd1);
        step(1'b0, 2'd0, 8'h00, 3'b110, acc);
        step(1'b0, 2'd0, 8'h00, 3'b111, acc);

        // Drops and saturation
        for (int k = 0; k < 5; k++) step(1'b1, 2'd3, 8'(k), 3'b111, acc);
        step(1'b0, 2'd0, 8'h00, 3'b111, acc);

        // Streaming, select cycling 0,1,2
        for (int k = 0; k < 8; k++) step(1'b1, 2'(k % 3), 8'(k), 3'b111, acc);
        step(1'b0, 2'd0, 8'h00, 3'b111, acc);

        // Fill all slots then reset mid-operation
        step(1'b1, 2'd0, 8'h11, 3'b000, acc);
        step(1'b1, 2'd1, 8'h22, 3'b000, acc);
        step(1'b1, 2'd2, 8'h33, 3'b000, acc);
        step(1'b1, 2'd3, 8'h44, 3'b000, acc);
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_drop_count", 32'(drop_count), 32'd0);
        check_eq("rst_drop_pulse", 32'(drop_pulse), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check_outputs();

        // Randomized traffic; producer holds an unaccepted beat
        pend = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!pend) begin
                p_sel = SW'($urandom_range(0, 3));
                p_dat = DW'($urandom);
                pend  = ($urandom_range(0, 3) != 0);
                if (!pend) step(1'b0, p_sel, p_dat, NO'($urandom), acc);
                else begin
                    step(1'b1, p_sel, p_dat, NO'($urandom), acc);
                    if (acc) pend = 1'b0;
                end
            end else begin
                step(1'b1, p_sel, p_dat, NO'($urandom), acc);
                if (acc) pend = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- 1-to-NUM_OUT registered stream demultiplexer with valid/ready handshake; the companion to the team's 2:1 mux.
- Routes each input beat to the output channel chosen by `in_select`.
- Each output has a one-entry holding slot, so output backpressure is absorbed per channel.
- Beats whose select is out of range are dropped and counted. Sits between a shared producer and several independent consumers.

Parameters:
- DATA_W, 8, data width per beat.
- NUM_OUT, 3, number of output channels (2..2**SEL_W).
- SEL_W, 2, width of `in_select`.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept the beat this cycle.
- in_data  input  DATA_W  input beat payload.
- in_select  input  SEL_W  destination channel for the beat.
- out_valid  output  NUM_OUT  per-channel slot holds a beat.
- out_ready  input  NUM_OUT  per-channel consumer accepts.
- out_data  output  NUM_OUT*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- drop_count  output  CNT_W  saturating count of dropped beats.
- drop_pulse  output  1  one-cycle pulse, cycle after a drop.

Behaviour:
- Reset (asynchronous assert, released synchronously by the driving environment):
  - out_valid=0, out_data=0, drop_count=0, drop_pulse=0.
  - All slots empty.
- Handshakes:
  - Accept = in_valid & in_ready.
  - Output transfer on channel i = out_valid[i] & out_ready[i].
- in_ready (combinational):
  - 1 when in_select >= NUM_OUT, because the beat will be dropped.
  - Otherwise `!out_valid[in_select] | out_ready[in_select]`, i.e. the slot is empty or draining this cycle.
  - in_ready depends on out_ready; it does not depend on in_valid.
- Accept to channel s < NUM_OUT:
  - Next cycle: out_valid[s]=1 and out_data[s]=in_data.
  - Latency is exactly 1 cycle from accept to out_valid.
- Simultaneous drain and accept on the same channel:
  - The slot reloads with the new beat and out_valid[s] stays 1.
  - Full throughput is 1 beat/cycle per channel.
- Drain without a new accept: out_valid[i] clears next cycle.
- Stall rule: while out_valid[i]=1 and out_ready[i]=0, out_data[i] is held stable. The slot is never overwritten while it is full and not draining.
- Channels are independent: a stalled channel blocks only beats addressed to it. Other channels keep draining, and beats for other channels are accepted.
- Accept with in_select >= NUM_OUT:
  - Beat discarded; no out_valid changes.
  - drop_count increments by 1 and saturates at 2**CNT_W-1 (no wrap).
  - drop_pulse=1 for exactly the next cycle.
- in_select and in_data are don't-care while in_valid=0. No state changes occur.
- When in_valid=1 and in_ready=0, the producer holds the beat. Nothing is lost or duplicated.
- Reset mid-operation: all held beats are discarded immediately and outputs go to their reset values. drop_count clears.
- No state machine beyond the per-slot full/empty bit. Per-channel state transitions:
  - EMPTY->FULL on accept.
  - FULL->EMPTY on drain without accept.
  - FULL->FULL on drain with accept, or on stall.

Decomposition:
- Shared package demux_pkg holds:
  - default DATA_W/NUM_OUT/SEL_W/CNT_W constants;
  - the drop-counter saturation value as a derived constant;
  - the per-channel slice-index helper for out_data.
- One natural sub-module, demux_slot: a one-entry holding register with load/drain and valid/ready. It is instantiated NUM_OUT times in a generate loop. The top level holds in_ready decode, select range check and the drop counter.

Test Plan:
- Reset during activity: fill all 3 slots with 0x11/0x22/0x33, then assert reset. Required: out_valid=000, out_data all zero, drop_count=0 immediately, before the next clk edge.
- Basic routing: out_ready=111; send 0xA5 with select=1. Required: next cycle out_valid=010 and out_data[1]=0xA5; the following cycle out_valid=000.
- Backpressure: out_ready[0]=0; send 0x10 then 0x20, both to select 0. Required:
  - 0x10 held in slot 0 and stable;
  - in_ready=0 for the second beat;
  - raise out_ready[0] and 0x10 transfers, then 0x20 is accepted in the same cycle;
  - out_valid[0] stays 1 with data 0x20.
- Independence: channel 0 stalled; send 0x55 to select 2 with out_ready[2]=1. Required: in_ready=1, out_valid[2]=1 next cycle, and slot 0 unchanged.
- Drop and saturate: CNT_W=2; send 5 beats with select=3. Required:
  - in_ready=1 for all 5;
  - drop_pulse high one cycle after each beat;
  - drop_count sequence 1,2,3,3,3;
  - out_valid never set.
- Streaming: out_ready=111; 8 back-to-back beats 0x00..0x07 with select cycling 0,1,2. Required: in_ready is constantly 1, each beat appears on its channel exactly 1 cycle later, and there are no gaps.
